seq_array_multiplier: RTL

Parametrised sequential shift-add multiplier: successor to the fixed 4x4 combinational array multiplier, generalised to WIDTH x WIDTH operands. One partial-product row is added per clock through a WIDTH-bit full-adder row instead of a full array of adder cells. Valid/ready handshakes on input and output let it sit between the tile input registers and the result path. Optionally supports two's-complement operands.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/fa_row.sv | 23 ++
 rtl/seq_array_multiplier.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fa_row.sv
// WIDTH-bit ripple row of full-adder cells with carry-in and carry-out.
module fa_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = x[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential shift-add WIDTH x WIDTH multiplier with valid/ready handshakes.
// Define MULT_SIGNED_EN to add the tc port and two's-complement operation.
module seq_array_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef MULT_SIGNED_EN
    input  logic                 tc,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int             CW   = clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cin;
    logic               cout;
    logic               top_bit;
    logic               last_step;

    assign last_step = (count == LAST);

`ifdef MULT_SIGNED_EN
    logic tc_q;
    logic sub;

    // Last multiplier bit carries negative weight: subtract M instead of adding it.
    assign sub = tc_q & last_step & prod[0];

    // Operand selection for the adder row, signed build.
    always_comb begin
        addend  = {WIDTH{1'b0}};
        cin     = 1'b0;
        top_bit = cout;
        if (prod[0]) begin
            addend = sub ? ~mcand : mcand;
        end else begin
            addend = {WIDTH{1'b0}};
        end
        cin = sub;
        if (tc_q) begin
            top_bit = prod[2*WIDTH-1] ^ addend[WIDTH-1] ^ cout;
        end else begin
            top_bit = cout;
        end
    end

    // Operand-type flag captured alongside the operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            tc_q <= tc;
        end else begin
            tc_q <= tc_q;
        end
    end
`else
    // Operand selection for the adder row, unsigned build.
    always_comb begin
        addend  = {WIDTH{1'b0}};
        cin     = 1'b0;
        top_bit = cout;
        if (prod[0]) begin
            addend = mcand;
        end else begin
            addend = {WIDTH{1'b0}};
        end
    end
`endif

    fa_row #(.WIDTH(WIDTH)) u_fa_row (
        .x    (prod[2*WIDTH-1:WIDTH]),
        .y    (addend),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) state_next = RUN;
                else          state_next = IDLE;
            end
            RUN: begin
                if (last_step) state_next = DONE;
                else           state_next = RUN;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
                else           state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and one shift-add step per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= {WIDTH{1'b0}};
            prod  <= {(2*WIDTH){1'b0}};
            count <= {CW{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        prod  <= {{WIDTH{1'b0}}, b};
                        count <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    prod  <= {top_bit, sum, prod[WIDTH-1:1]};
                    count <= count + CW'(1);
                end
                default: begin
                    prod <= prod;
                end
            endcase
        end
    end

    assign product   = prod;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign in_ready  = (state == IDLE) & ~rst;

endmodule
